lcd_text_ctrl: RTL and testbench

Parametrised character-LCD controller for HD44780-compatible 8-bit-bus modules. It runs the power-up and initialisation sequence, then holds a ROWS x COLS character buffer that the host writes one byte at a time. Whenever the buffer changes, the block repaints the whole display. It is the buffered, size-generic successor to the team's fixed-text LCD front-end. E is now a properly timed strobe rather than the raw clock.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_bus_slot.sv | 70 +++++++
 rtl/lcd_text_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller.
// Contents:
//   - HD44780 command bytes used during init and repaint
//   - controller FSM state type
//   - row_ofs(): DDRAM start address of a display row
package lcd_pkg;

    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    typedef enum logic [3:0] {
        PWR_WAIT,
        FUNC,
        DISP,
        ENTRY,
        CLR,
        CLR_WAIT,
        IDLE,
        ROW_CMD,
        CHAR
    } lcd_state_t;

    // Rows 2/3 are the continuation of rows 0/1 in DDRAM, so their
    // offsets depend on the display width.
    function automatic logic [7:0] row_ofs(input logic [1:0] row, input int unsigned cols);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(cols);
            default: return 8'(32'h40 + cols);
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_slot.sv
// One HD44780 bus write transaction of 4*E_DIV cycles.
// Ports:
//   CLK, RESETN  clock, asynchronous active-low reset
//   start        request a transaction (accepted only while !active)
//   rs, data     register select and byte, captured on accept
//   lcd_e        enable strobe: low E_DIV, high E_DIV, low 2*E_DIV cycles
//   lcd_rs       held RS for the whole slot
//   lcd_data     held bus byte for the whole slot
//   active       a transaction is in progress
//   done         high on the last cycle of the slot
module lcd_bus_slot #(
    parameter int unsigned E_DIV = 25
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       active,
    output logic       done
);

    localparam int unsigned SLOT = 4 * E_DIV;
    localparam int unsigned CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

    logic [CW-1:0] cnt, cnt_n;
    logic          active_n;
    logic          accept;

    assign accept = start && !active;
    assign done   = active && (cnt == CW'(SLOT - 1));

    always_comb begin
        cnt_n    = cnt;
        active_n = active;
        if (accept) begin
            active_n = 1'b1;
            cnt_n    = '0;
        end else if (done) begin
            active_n = 1'b0;
            cnt_n    = '0;
        end else if (active) begin
            cnt_n = cnt + 1'b1;
        end
    end

    // E is registered from the next-count value so the strobe is glitch-free
    // and aligned exactly with slot cycles [E_DIV, 2*E_DIV).
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt      <= '0;
            active   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            cnt    <= cnt_n;
            active <= active_n;
            lcd_e  <= active_n && (cnt_n >= CW'(E_DIV)) && (cnt_n < CW'(2 * E_DIV));
            if (accept) begin
                lcd_rs   <= rs;
                lcd_data <= data;
            end
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// Buffered HD44780 8-bit-bus text controller.
// Runs power-up/init, then repaints the whole ROWS x COLS buffer whenever
// the host has written it.
// Ports:
//   CLK, RESETN        clock, asynchronous active-low reset
//   WR_EN/ADDR/DATA    host byte write, ADDR = row*COLS+col (out of range ignored)
//   BUSY               init running, repaint running or repaint pending
//   INIT_DONE          sticky, set when initialisation completes
//   LCD_E/RS/RW/DATA   LCD bus (RW tied low)
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned ROWS        = 2,
    parameter int unsigned COLS        = 16,
    parameter int unsigned E_DIV       = 25,
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned CLEAR_CYC   = 80000,
    parameter logic [7:0]  FUNC_WORD   = 8'h38,
    localparam int unsigned AW         = $clog2(ROWS * COLS)
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [7:0]    WR_DATA,
    output logic          BUSY,
    output logic          INIT_DONE,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic [7:0]    LCD_DATA
);

    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned WMAX  = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int unsigned WW    = $clog2(WMAX + 1);
    localparam int unsigned CLW   = $clog2(COLS);

    lcd_state_t       state, state_n;
    logic [WW-1:0]    wait_cnt, wait_n;
    logic [1:0]       row, row_n;
    logic [CLW-1:0]   col, col_n;
    logic             dirty, dirty_clr, init_set;
    logic [7:0]       char_buf [DEPTH];
    logic [AW-1:0]    idx;
    logic             wr_ok;

    logic             slot_start, slot_rs, slot_active, slot_done;
    logic [7:0]       slot_data;

    assign wr_ok  = WR_EN && (32'(WR_ADDR) < DEPTH);
    assign idx    = AW'(32'(row) * COLS + 32'(col));
    assign BUSY   = (state != IDLE) || dirty;
    assign LCD_RW = 1'b0;

    lcd_bus_slot #(.E_DIV(E_DIV)) u_slot (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .start    (slot_start),
        .rs       (slot_rs),
        .data     (slot_data),
        .lcd_e    (LCD_E),
        .lcd_rs   (LCD_RS),
        .lcd_data (LCD_DATA),
        .active   (slot_active),
        .done     (slot_done)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= PWR_WAIT;
        else         state <= state_n;
    end

    // Sending states request a slot whenever the bus is free and advance on
    // its done pulse. The character byte is read from the buffer at slot
    // start, so late writes to unsent cells appear in the current pass.
    always_comb begin
        state_n    = state;
        wait_n     = '0;
        row_n      = row;
        col_n      = col;
        dirty_clr  = 1'b0;
        init_set   = 1'b0;
        slot_start = 1'b0;
        slot_rs    = 1'b0;
        slot_data  = '0;
        case (state)
            PWR_WAIT: begin
                wait_n = wait_cnt + 1'b1;
                if (wait_cnt == WW'(POWERUP_CYC - 1)) begin
                    wait_n  = '0;
                    state_n = FUNC;
                end
            end
            FUNC: begin
                slot_start = !slot_active;
                slot_data  = FUNC_WORD;
                if (slot_done) state_n = DISP;
            end
            DISP: begin
                slot_start = !slot_active;
                slot_data  = CMD_DISP_ON;
                if (slot_done) state_n = ENTRY;
            end
            ENTRY: begin
                slot_start = !slot_active;
                slot_data  = CMD_ENTRY;
                if (slot_done) state_n = CLR;
            end
            CLR: begin
                slot_start = !slot_active;
                slot_data  = CMD_CLEAR;
                if (slot_done) state_n = CLR_WAIT;
            end
            CLR_WAIT: begin
                wait_n = wait_cnt + 1'b1;
                if (wait_cnt == WW'(CLEAR_CYC - 1)) begin
                    wait_n   = '0;
                    init_set = 1'b1;
                    state_n  = IDLE;
                end
            end
            IDLE: begin
                if (dirty) begin
                    dirty_clr = 1'b1;
                    row_n     = '0;
                    state_n   = ROW_CMD;
                end
            end
            ROW_CMD: begin
                slot_start = !slot_active;
                slot_data  = CMD_DDRAM | row_ofs(row, COLS);
                if (slot_done) begin
                    col_n   = '0;
                    state_n = CHAR;
                end
            end
            CHAR: begin
                slot_start = !slot_active;
                slot_rs    = 1'b1;
                slot_data  = char_buf[idx];
                if (slot_done) begin
                    if (col < CLW'(COLS - 1)) begin
                        col_n = col + 1'b1;
                    end else if (row < 2'(ROWS - 1)) begin
                        row_n   = row + 1'b1;
                        state_n = ROW_CMD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    // A host write in the same cycle IDLE consumes dirty keeps it set.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wait_cnt  <= '0;
            row       <= '0;
            col       <= '0;
            dirty     <= 1'b0;
            INIT_DONE <= 1'b0;
            char_buf  <= '{default: 8'h20};
        end else begin
            wait_cnt <= wait_n;
            row      <= row_n;
            col      <= col_n;
            dirty    <= (dirty && !dirty_clr) || wr_ok;
            if (init_set) INIT_DONE <= 1'b1;
            if (wr_ok)    char_buf[WR_ADDR] <= WR_DATA;
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Self-checking bench for lcd_text_ctrl (4x20 display, short timings).
// Bytes are captured at every LCD_E falling edge and compared with a
// reference stream built from a model of the character buffer.
module tb_lcd_text_ctrl;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 20;
    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [7:0]    WR_DATA;
    logic          BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]    LCD_DATA;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] mdl [DEPTH];

    always #5 CLK = ~CLK;

    lcd_text_ctrl #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .E_DIV       (2),
        .POWERUP_CYC (20),
        .CLEAR_CYC   (10),
        .FUNC_WORD   (8'h38)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .BUSY      (BUSY),
        .INIT_DONE (INIT_DONE),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
    );

    always @(negedge LCD_E) if (RESETN) obs_q.push_back({LCD_RS, LCD_DATA});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Full repaint: per row a DDRAM address command then every character.
    task automatic push_pass();
        for (int r = 0; r < int'(ROWS); r++) begin
            int ofs = (r % 2) * 64 + (r / 2) * int'(COLS);
            exp_q.push_back({1'b0, 8'h80 | 8'(ofs)});
            for (int c = 0; c < int'(COLS); c++) exp_q.push_back({1'b1, mdl[r * COLS + c]});
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (BUSY && i < 4000) begin
            @(negedge CLK);
            i++;
        end
        chk({tag, "_idle_timeout"}, BUSY, 0);
    endtask

    task automatic do_init();
        logic e_seen = 1'b0;
        int i = 0;
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (20) begin
            @(posedge CLK);
            #1 if (LCD_E) e_seen = 1'b1;
        end
        chk("pwr_quiet", e_seen, 0);
        while (!INIT_DONE && i < 1000) begin
            @(negedge CLK);
            i++;
        end
        chk("init_done", INIT_DONE, 1);
        chk("init_busy", BUSY, 0);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        check_stream("init_seq");
        repeat (40) @(negedge CLK);
        chk("post_init_quiet", obs_q.size(), 0);
    endtask

    task automatic oob_write();
        logic busy_seen = 1'b0;
        logic [AW-1:0] a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
        do_write(a, 8'h5A);
        repeat (30) begin
            @(negedge CLK);
            if (BUSY) busy_seen = 1'b1;
        end
        chk("oob_busy", busy_seen, 0);
        chk("oob_pulses", obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESETN = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 8'h20;
        repeat (3) @(negedge CLK);
        chk("rst_e", LCD_E, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_data", LCD_DATA, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_init", INIT_DONE, 0);

        do_init();

        // single write, one pass
        do_write(0, 8'h48);
        mdl[0] = 8'h48;
        chk("busy_after_wr", BUSY, 1);
        push_pass();
        wait_idle("pass1");
        check_stream("pass1");

        // write to an unsent cell during a pass: shown now, plus one more pass
        begin
            int i = 0;
            do_write(2, 8'h31);
            while (obs_q.size() < 3 && i < 200) begin
                @(negedge CLK);
                i++;
            end
            chk("midpass_wait", obs_q.size() >= 3, 1);
            do_write(21, 8'h41);
            mdl[2]  = 8'h31;
            mdl[21] = 8'h41;
            push_pass();
            push_pass();
            wait_idle("midpass");
            check_stream("midpass");
        end

        oob_write();

        // random traffic: bursts of back-to-back writes or out-of-range writes
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                oob_write();
            end else begin
                int n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
                    logic [7:0]    d = 8'($urandom_range(8'h21, 8'h7E));
                    @(negedge CLK);
                    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
                    mdl[a] = d;
                end
                @(negedge CLK);
                WR_EN = 1'b0;
                chk("burst_busy", BUSY, 1);
                // a write arriving once the pass has begun forces one more pass
                push_pass();
                if (n > 1) push_pass();
                wait_idle("burst");
                check_stream("burst");
            end
        end

        // asynchronous reset while a character strobe is high
        begin
            int i = 0;
            do_write(79, 8'h7A);
            while (!(LCD_RS && LCD_E) && i < 2000) begin
                @(posedge CLK);
                #2;
                i++;
            end
            chk("char_strobe_seen", LCD_RS && LCD_E, 1);
            RESETN = 1'b0;
            #1;
            chk("async_e", LCD_E, 0);
            chk("async_rs", LCD_RS, 0);
            chk("async_data", LCD_DATA, 0);
            chk("async_busy", BUSY, 1);
            chk("async_init", INIT_DONE, 0);
            repeat (2) @(negedge CLK);
            obs_q.delete();
            exp_q.delete();
            for (int j = 0; j < int'(DEPTH); j++) mdl[j] = 8'h20;
            do_init();
            do_write(40, 8'h55);
            mdl[40] = 8'h55;
            push_pass();
            wait_idle("post_reset");
            check_stream("post_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
